// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART frame parser.
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CSUM
  } parser_state_e;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_byte_timer.sv
// uart_byte_timer: clearable, enabled, saturating cycle counter with a one-cycle expire strobe.
module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 400
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  assign expire_o = en_i && !clr_i && cnt_q == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles HEADER/CMD/ADDR/DATA/CSUM frames from received bytes,
// pulsing frm_valid_o on a good XOR checksum and err_o on checksum error or inter-byte timeout.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int UART_BPS = 115200,
  parameter int TIMEOUT_BYTES = 4,
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       rx_done_i,
  input  logic [7:0] rx_data_i,
  output logic       frm_valid_o,
  output logic [7:0] frm_cmd_o,
  output logic [7:0] frm_addr_o,
  output logic [7:0] frm_data_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);
  localparam int TIMEOUT_CYCLES = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
  parser_state_e state_q, state_d;
  logic [7:0] csum_q, csum_d, cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic [7:0] fcmd_q, fcmd_d, faddr_q, faddr_d, fdata_q, fdata_d;
  logic valid_q, valid_d, err_q, err_d;
  logic [1:0] code_q, code_d;
  logic expire;
  uart_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .en_i     (state_q != S_IDLE),
    .clr_i    (rx_done_i || state_q == S_IDLE),
    .expire_o (expire)
  );
  always_comb begin
    state_d = state_q;
    csum_d = csum_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    data_d = data_q;
    fcmd_d = fcmd_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    code_d = code_q;
    if (rx_done_i) begin
      case (state_q)
        S_IDLE: if (rx_data_i == HEADER) begin
          state_d = S_CMD;
          csum_d = '0;
        end
        S_CMD: begin
          cmd_d = rx_data_i;
          csum_d = rx_data_i;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d = rx_data_i;
          csum_d = csum_q ^ rx_data_i;
          state_d = S_DATA;
        end
        S_DATA: begin
          data_d = rx_data_i;
          csum_d = csum_q ^ rx_data_i;
          state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          if (rx_data_i == csum_q) begin
            fcmd_d = cmd_q;
            faddr_d = addr_q;
            fdata_d = data_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
            code_d = ERR_CSUM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire) begin
      state_d = S_IDLE;
      err_d = 1'b1;
      code_d = ERR_TIMEOUT;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      csum_q <= '0;
      cmd_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      fcmd_q <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      csum_q <= csum_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      fcmd_q <= fcmd_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      valid_q <= valid_d;
      err_q <= err_d;
      code_q <= code_d;
    end
  assign frm_valid_o = valid_q;
  assign frm_cmd_o = fcmd_q;
  assign frm_addr_o = faddr_q;
  assign frm_data_o = fdata_q;
  assign err_o = err_q;
  assign err_code_o = code_q;
  assign busy_o = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed frames with hand-computed expectations for uart_frame_parser.
module tb_uart_frame_parser;
  logic clk_i = 0;
  logic rst_n = 0;
  logic rx_done_i = 0;
  logic [7:0] rx_data_i = '0;
  logic frm_valid_o, err_o, busy_o;
  logic [7:0] frm_cmd_o, frm_addr_o, frm_data_o;
  logic [1:0] err_code_o;
  int cmps = 0;
  int errs = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  uart_frame_parser #(
    .CLK_FREQ(1_000_000),
    .UART_BPS(100_000),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .rx_done_i   (rx_done_i),
    .rx_data_i   (rx_data_i),
    .frm_valid_o (frm_valid_o),
    .frm_cmd_o   (frm_cmd_o),
    .frm_addr_o  (frm_addr_o),
    .frm_data_o  (frm_data_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .busy_o      (busy_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    n_valid += int'(frm_valid_o);
    n_err += int'(err_o);
    n_both += int'(frm_valid_o && err_o);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk_i) #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_done_i = 1'b1;
    rx_data_i = b;
    @(posedge clk_i) #1;
    rx_done_i = 1'b0;
  endtask
  task automatic frame(input logic [39:0] f, input int gap);
    for (int i = 0; i < 5; i++) begin
      send(f[39-8*i -: 8]);
      if (i < 4) idle(gap);
    end
  endtask
  task automatic chk_good(input string tag, input logic [23:0] fields);
    chk({tag, ".valid"}, frm_valid_o, 1);
    chk({tag, ".err"}, err_o, 0);
    chk({tag, ".fields"}, {frm_cmd_o, frm_addr_o, frm_data_o}, fields);
    chk({tag, ".busy"}, busy_o, 0);
    idle(1);
    chk({tag, ".pulse"}, frm_valid_o, 0);
  endtask
  initial begin
    int e0;
    idle(3);
    chk("rst.outs", {frm_valid_o, err_o, err_code_o, busy_o}, 0);
    chk("rst.fields", {frm_cmd_o, frm_addr_o, frm_data_o}, 0);
    rst_n = 1'b1;
    idle(2);
    frame(40'hA5_01_10_3C_2C, 99);
    chk("bad.err", err_o, 1);
    chk("bad.code", err_code_o, 2'b01);
    chk("bad.valid", frm_valid_o, 0);
    chk("bad.fields", {frm_cmd_o, frm_addr_o, frm_data_o}, 0);
    idle(1);
    chk("bad.pulse", err_o, 0);
    chk("bad.code_hold", err_code_o, 2'b01);
    idle(98);
    frame(40'hA5_01_10_3C_2D, 99);
    chk_good("good", 24'h01_10_3C);
    idle(98);
    e0 = n_err;
    send(8'h00); idle(99);
    send(8'hFF); idle(99);
    send(8'h5A); idle(99);
    chk("garbage.busy", busy_o, 0);
    chk("garbage.err", n_err, e0);
    frame(40'hA5_22_33_44_55, 99);
    chk_good("garb_frame", 24'h22_33_44);
    idle(98);
    send(8'hA5); idle(99);
    send(8'h01);
    idle(399);
    chk("to.before_err", err_o, 0);
    chk("to.before_busy", busy_o, 1);
    idle(1);
    chk("to.err", err_o, 1);
    chk("to.code", err_code_o, 2'b10);
    chk("to.busy", busy_o, 0);
    chk("to.fields", {frm_cmd_o, frm_addr_o, frm_data_o}, 24'h22_33_44);
    idle(99);
    frame(40'hA5_7E_00_00_7E, 99);
    chk_good("post_to", 24'h7E_00_00);
    chk("post_to.code", err_code_o, 2'b10);
    idle(50);
    frame(40'hA5_0F_F0_AA_55, 0);
    chk_good("b2b", 24'h0F_F0_AA);
    idle(50);
    send(8'hA5); idle(99);
    send(8'h01); idle(99);
    send(8'h10); idle(50);
    chk("rst_mid.busy_pre", busy_o, 1);
    rst_n = 1'b0;
    idle(3);
    chk("rst_mid.outs", {frm_valid_o, err_o, err_code_o, busy_o}, 0);
    chk("rst_mid.fields", {frm_cmd_o, frm_addr_o, frm_data_o}, 0);
    rst_n = 1'b1;
    idle(600);
    chk("rst_mid.no_err", err_o, 0);
    frame(40'hA5_01_10_3C_2D, 99);
    chk_good("post_rst", 24'h01_10_3C);
    idle(10);
    chk("total.valid", n_valid, 5);
    chk("total.err", n_err, 2);
    chk("total.overlap", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
